ysyx_22050710_wsu: RTL and testbench

- Write-back stage controller: the MEM→WB pipeline register plus load-data completion.
- Accepts one instruction per cycle from the memory stage through a valid/allowin handshake.
- For loads, holds the instruction until the data-memory response arrives, then extracts and extends the loaded value.
- Presents exactly one cycle of valid write-back fields to the downstream write-back unit, which drives the GPR/CSR register-file write bus.

---
 rtl/ysyx_22050710_wsu_pkg.sv | 27 ++
 rtl/ysyx_22050710_load_ext.sv | 44 ++++
 rtl/ysyx_22050710_wsu.sv | 154 +++++++++++++++
 tb/tb_ysyx_22050710_wsu.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050710_wsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050710_wsu_pkg
// Purpose  : Shared definitions for the write-back stage controller:
//            the WB state encoding and the load funct3 codes.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_22050710_wsu_pkg;

  // WB stage occupancy: empty, load waiting on dmem, result presented
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } ws_state_e;

  // Load funct3 encodings
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LD  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;
  localparam logic [2:0] LD_LWU = 3'b110;

endpackage
`default_nettype wire

// File: rtl/ysyx_22050710_load_ext.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050710_load_ext
// Purpose  : Combinational load-data formatter. Shifts the addressed bytes of
//            the aligned doubleword down to bit 0 and sign/zero-extends them
//            according to the load funct3. Unknown funct3 (111) yields 0.
// Ports    : rdata  in  GPR_WD  aligned doubleword from data memory
//            offset in  3       byte offset of the load within the doubleword
//            op     in  3       load funct3
//            result out GPR_WD  extended load value
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050710_load_ext
  import ysyx_22050710_wsu_pkg::*;
#(
  parameter int GPR_WD = 64
) (
  input  logic [GPR_WD-1:0] rdata,
  input  logic [2:0]        offset,
  input  logic [2:0]        op,
  output logic [GPR_WD-1:0] result
);

  logic [GPR_WD-1:0] raw;

  // Byte offset -> bit shift
  assign raw = rdata >> {offset, 3'b000};

  always_comb begin
    result = '0;
    case (op)
      LD_LB:   result = GPR_WD'($signed(raw[7:0]));
      LD_LH:   result = GPR_WD'($signed(raw[15:0]));
      LD_LW:   result = GPR_WD'($signed(raw[31:0]));
      LD_LD:   result = raw;
      LD_LBU:  result = GPR_WD'(raw[7:0]);
      LD_LHU:  result = GPR_WD'(raw[15:0]);
      LD_LWU:  result = GPR_WD'(raw[31:0]);
      default: result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_22050710_wsu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050710_wsu
// Purpose  : Write-back stage controller. Holds the MEM->WB pipeline register,
//            stalls loads until the data-memory response arrives, formats the
//            loaded value, and presents one cycle of valid write-back fields.
// Ports    : i_clk / i_rst           clock, async active-high reset
//            i_ms_valid/o_ws_allowin MEM->WB handshake
//            i_ms_*                  instruction fields from the memory stage
//            i_dmem_rvalid/rdata     load response
//            o_ws_valid, o_ws_pc     retiring instruction
//            o_gpr_*, o_csr_*        register-file write fields
//            o_minstret              retired-instruction count
// Config   : WS_PERF_CNT_EN - when defined, o_minstret is a live 64-bit
//            counter; otherwise it is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050710_wsu
  import ysyx_22050710_wsu_pkg::*;
#(
  parameter int GPR_ADDR_WD = 5,
  parameter int GPR_WD      = 64,
  parameter int CSR_ADDR_WD = 12,
  parameter int CSR_WD      = 64,
  parameter int PC_WD       = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_ms_valid,
  output logic                   o_ws_allowin,
  input  logic [PC_WD-1:0]       i_ms_pc,
  input  logic                   i_ms_gpr_wen,
  input  logic [GPR_ADDR_WD-1:0] i_ms_gpr_waddr,
  input  logic [GPR_WD-1:0]      i_ms_alu_result,
  input  logic                   i_ms_is_load,
  input  logic [2:0]             i_ms_load_op,
  input  logic                   i_ms_csr_wen,
  input  logic [CSR_ADDR_WD-1:0] i_ms_csr_waddr,
  input  logic [CSR_WD-1:0]      i_ms_csr_wdata,
  input  logic                   i_dmem_rvalid,
  input  logic [GPR_WD-1:0]      i_dmem_rdata,
  output logic                   o_ws_valid,
  output logic [PC_WD-1:0]       o_ws_pc,
  output logic                   o_gpr_wen,
  output logic [GPR_ADDR_WD-1:0] o_gpr_waddr,
  output logic [GPR_WD-1:0]      o_gpr_wdata,
  output logic                   o_csr_wen,
  output logic [CSR_ADDR_WD-1:0] o_csr_waddr,
  output logic [CSR_WD-1:0]      o_csr_wdata,
  output logic [63:0]            o_minstret
);

  ws_state_e              state;
  logic [PC_WD-1:0]       pc_q;
  logic                   gpr_wen_q;
  logic [GPR_ADDR_WD-1:0] gpr_waddr_q;
  logic [GPR_WD-1:0]      gpr_wdata_q;
  logic                   csr_wen_q;
  logic [CSR_ADDR_WD-1:0] csr_waddr_q;
  logic [CSR_WD-1:0]      csr_wdata_q;
  logic [2:0]             load_op_q;
  logic [2:0]             load_off_q;

  logic                   allowin;
  logic                   accept;
  logic [GPR_WD-1:0]      load_data;

  // Downstream never stalls, so DONE always frees the slot for a new entry
  assign allowin = (state == ST_IDLE) || (state == ST_DONE);
  assign accept  = i_ms_valid && allowin;

  // Offset and funct3 are the latched copies; only rdata is live here, and
  // its formatted value goes into a register before reaching any output.
  ysyx_22050710_load_ext #(
    .GPR_WD (GPR_WD)
  ) u_load_ext (
    .rdata  (i_dmem_rdata),
    .offset (load_off_q),
    .op     (load_op_q),
    .result (load_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      pc_q        <= '0;
      gpr_wen_q   <= 1'b0;
      gpr_waddr_q <= '0;
      gpr_wdata_q <= '0;
      csr_wen_q   <= 1'b0;
      csr_waddr_q <= '0;
      csr_wdata_q <= '0;
      load_op_q   <= '0;
      load_off_q  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            pc_q        <= i_ms_pc;
            gpr_wen_q   <= i_ms_gpr_wen;
            gpr_waddr_q <= i_ms_gpr_waddr;
            // For loads this is replaced by the formatted data in WAIT
            gpr_wdata_q <= i_ms_alu_result;
            csr_wen_q   <= i_ms_csr_wen;
            csr_waddr_q <= i_ms_csr_waddr;
            csr_wdata_q <= i_ms_csr_wdata;
            load_op_q   <= i_ms_load_op;
            load_off_q  <= i_ms_alu_result[2:0];
            state       <= i_ms_is_load ? ST_WAIT : ST_DONE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          // A response is only meaningful while a load is outstanding
          if (i_dmem_rvalid) begin
            gpr_wdata_q <= load_data;
            state       <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_ws_allowin = allowin;
  assign o_ws_valid   = (state == ST_DONE);
  assign o_ws_pc      = pc_q;
  assign o_gpr_wen    = gpr_wen_q;
  assign o_gpr_waddr  = gpr_waddr_q;
  assign o_gpr_wdata  = gpr_wdata_q;
  assign o_csr_wen    = csr_wen_q;
  assign o_csr_waddr  = csr_waddr_q;
  assign o_csr_wdata  = csr_wdata_q;

`ifdef WS_PERF_CNT_EN
  logic [63:0] minstret_q;

  // Wraps naturally from all-ones to zero
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      minstret_q <= '0;
    end else if (state == ST_DONE) begin
      minstret_q <= minstret_q + 64'd1;
    end
  end

  assign o_minstret = minstret_q;
`else
  assign o_minstret = 64'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050710_wsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22050710_wsu
// Purpose  : Directed self-checking bench for ysyx_22050710_wsu.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050710_wsu;

  logic        clk;
  logic        rst;
  logic        ms_valid;
  logic        ws_allowin;
  logic [63:0] ms_pc;
  logic        ms_gpr_wen;
  logic [4:0]  ms_gpr_waddr;
  logic [63:0] ms_alu_result;
  logic        ms_is_load;
  logic [2:0]  ms_load_op;
  logic        ms_csr_wen;
  logic [11:0] ms_csr_waddr;
  logic [63:0] ms_csr_wdata;
  logic        dmem_rvalid;
  logic [63:0] dmem_rdata;
  logic        ws_valid;
  logic [63:0] ws_pc;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [63:0] gpr_wdata;
  logic        csr_wen;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata;
  logic [63:0] minstret;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_22050710_wsu dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_ms_valid      (ms_valid),
    .o_ws_allowin    (ws_allowin),
    .i_ms_pc         (ms_pc),
    .i_ms_gpr_wen    (ms_gpr_wen),
    .i_ms_gpr_waddr  (ms_gpr_waddr),
    .i_ms_alu_result (ms_alu_result),
    .i_ms_is_load    (ms_is_load),
    .i_ms_load_op    (ms_load_op),
    .i_ms_csr_wen    (ms_csr_wen),
    .i_ms_csr_waddr  (ms_csr_waddr),
    .i_ms_csr_wdata  (ms_csr_wdata),
    .i_dmem_rvalid   (dmem_rvalid),
    .i_dmem_rdata    (dmem_rdata),
    .o_ws_valid      (ws_valid),
    .o_ws_pc         (ws_pc),
    .o_gpr_wen       (gpr_wen),
    .o_gpr_waddr     (gpr_waddr),
    .o_gpr_wdata     (gpr_wdata),
    .o_csr_wen       (csr_wen),
    .o_csr_waddr     (csr_waddr),
    .o_csr_wdata     (csr_wdata),
    .o_minstret      (minstret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ms_valid      = 1'b0;
    ms_pc         = '0;
    ms_gpr_wen    = 1'b0;
    ms_gpr_waddr  = '0;
    ms_alu_result = '0;
    ms_is_load    = 1'b0;
    ms_load_op    = '0;
    ms_csr_wen    = 1'b0;
    ms_csr_waddr  = '0;
    ms_csr_wdata  = '0;
    dmem_rvalid   = 1'b0;
    dmem_rdata    = '0;
  endtask

  task automatic drive_alu(input logic [63:0] pc, input logic [4:0] rd, input logic [63:0] res);
    drive_idle();
    ms_valid      = 1'b1;
    ms_pc         = pc;
    ms_gpr_wen    = 1'b1;
    ms_gpr_waddr  = rd;
    ms_alu_result = res;
  endtask

  task automatic drive_load(input logic [63:0] pc, input logic [4:0] rd,
                            input logic [63:0] addr, input logic [2:0] op);
    drive_idle();
    ms_valid      = 1'b1;
    ms_pc         = pc;
    ms_gpr_wen    = 1'b1;
    ms_gpr_waddr  = rd;
    ms_alu_result = addr;
    ms_is_load    = 1'b1;
    ms_load_op    = op;
  endtask

  // Load at offset 0 with an immediate response in its WAIT cycle
  task automatic run_load(input string tag, input logic [2:0] op,
                          input logic [63:0] rdata, input logic [63:0] exp);
    drive_load(64'h400, 5'd7, 64'h1000, op);
    tick();
    drive_idle();
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    tick();
    drive_idle();
    check_eq({tag, "_valid"}, {63'd0, ws_valid}, 64'd1);
    check_eq(tag, gpr_wdata, exp);
  endtask

  localparam logic [63:0] MAT = 64'hF1E2_D3C4_B5A6_9788;
  logic [63:0] exp_minstret;

  initial begin
    rst = 1'b0;
    drive_idle();

    // Asynchronous reset, checked before any clock edge
    #1 rst = 1'b1;
    #1;
    check_eq("rst_valid",     {63'd0, ws_valid}, 64'd0);
    check_eq("rst_allowin",   {63'd0, ws_allowin}, 64'd1);
    check_eq("rst_pc",        ws_pc, 64'd0);
    check_eq("rst_gpr_wen",   {63'd0, gpr_wen}, 64'd0);
    check_eq("rst_gpr_waddr", {59'd0, gpr_waddr}, 64'd0);
    check_eq("rst_gpr_wdata", gpr_wdata, 64'd0);
    check_eq("rst_csr_wen",   {63'd0, csr_wen}, 64'd0);
    check_eq("rst_csr_waddr", {52'd0, csr_waddr}, 64'd0);
    check_eq("rst_csr_wdata", csr_wdata, 64'd0);
    check_eq("rst_minstret",  minstret, 64'd0);
    #10 rst = 1'b0;
    tick();

    // Back-to-back ALU ops
    drive_alu(64'h100, 5'd1, 64'h11);
    check_eq("b2b_allowin0", {63'd0, ws_allowin}, 64'd1);
    tick();
    check_eq("b2b1_valid", {63'd0, ws_valid}, 64'd1);
    check_eq("b2b1_waddr", {59'd0, gpr_waddr}, 64'd1);
    check_eq("b2b1_wdata", gpr_wdata, 64'h11);
    check_eq("b2b1_pc",    ws_pc, 64'h100);
    check_eq("b2b1_allowin", {63'd0, ws_allowin}, 64'd1);
    drive_alu(64'h104, 5'd2, 64'h22);
    ms_csr_wen   = 1'b1;
    ms_csr_waddr = 12'h305;
    ms_csr_wdata = 64'hABCD;
    tick();
    check_eq("b2b2_valid", {63'd0, ws_valid}, 64'd1);
    check_eq("b2b2_waddr", {59'd0, gpr_waddr}, 64'd2);
    check_eq("b2b2_wdata", gpr_wdata, 64'h22);
    check_eq("b2b2_csr_wen",   {63'd0, csr_wen}, 64'd1);
    check_eq("b2b2_csr_waddr", {52'd0, csr_waddr}, 64'h305);
    check_eq("b2b2_csr_wdata", csr_wdata, 64'hABCD);
    check_eq("b2b2_allowin", {63'd0, ws_allowin}, 64'd1);
    drive_alu(64'h108, 5'd3, 64'h33);
    tick();
    check_eq("b2b3_valid", {63'd0, ws_valid}, 64'd1);
    check_eq("b2b3_waddr", {59'd0, gpr_waddr}, 64'd3);
    check_eq("b2b3_wdata", gpr_wdata, 64'h33);
    check_eq("b2b3_csr_wen", {63'd0, csr_wen}, 64'd0);
    check_eq("b2b3_allowin", {63'd0, ws_allowin}, 64'd1);
    drive_idle();
    tick();
    check_eq("b2b_end_valid", {63'd0, ws_valid}, 64'd0);

    // Load stall: LB at offset 5, response three cycles after accept
    drive_load(64'h200, 5'd5, 64'h8000_0005, 3'b000);
    tick();
    drive_idle();
    check_eq("stall1_allowin", {63'd0, ws_allowin}, 64'd0);
    check_eq("stall1_valid",   {63'd0, ws_valid}, 64'd0);
    tick();
    check_eq("stall2_allowin", {63'd0, ws_allowin}, 64'd0);
    tick();
    check_eq("stall3_allowin", {63'd0, ws_allowin}, 64'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 64'h0000_8000_0000_0000;
    tick();
    drive_idle();
    check_eq("stall_valid",   {63'd0, ws_valid}, 64'd1);
    check_eq("stall_wdata",   gpr_wdata, 64'hFFFF_FFFF_FFFF_FF80);
    check_eq("stall_waddr",   {59'd0, gpr_waddr}, 64'd5);
    check_eq("stall_pc",      ws_pc, 64'h200);
    check_eq("stall_allowin", {63'd0, ws_allowin}, 64'd1);

    // Fifth retirement, then the counter
    drive_alu(64'h204, 5'd6, 64'h66);
    tick();
    drive_idle();
    check_eq("alu5_valid", {63'd0, ws_valid}, 64'd1);
    check_eq("alu5_wdata", gpr_wdata, 64'h66);
    tick();
    check_eq("alu5_end_valid", {63'd0, ws_valid}, 64'd0);
`ifdef WS_PERF_CNT_EN
    exp_minstret = 64'd5;
`else
    exp_minstret = 64'd0;
`endif
    check_eq("minstret_5", minstret, exp_minstret);

    // Extension matrix
    run_load("lb",  3'b000, MAT, 64'hFFFF_FFFF_FFFF_FF88);
    run_load("lbu", 3'b100, MAT, 64'h0000_0000_0000_0088);
    run_load("lh",  3'b001, MAT, 64'hFFFF_FFFF_FFFF_9788);
    run_load("lhu", 3'b101, MAT, 64'h0000_0000_0000_9788);
    run_load("lw",  3'b010, MAT, 64'hFFFF_FFFF_B5A6_9788);
    run_load("lwu", 3'b110, MAT, 64'h0000_0000_B5A6_9788);
    run_load("ld",  3'b011, MAT, 64'hF1E2_D3C4_B5A6_9788);
    run_load("op7", 3'b111, MAT, 64'd0);
    tick();
    check_eq("mat_end_valid", {63'd0, ws_valid}, 64'd0);

    // Spurious response while idle
    dmem_rvalid = 1'b1;
    dmem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    drive_idle();
    check_eq("spur_valid",   {63'd0, ws_valid}, 64'd0);
    check_eq("spur_wdata",   gpr_wdata, 64'd0);
    check_eq("spur_allowin", {63'd0, ws_allowin}, 64'd1);

    // Reset during WAIT, then a late response
    drive_load(64'h300, 5'd9, 64'h2000, 3'b011);
    tick();
    drive_idle();
    check_eq("rw_allowin", {63'd0, ws_allowin}, 64'd0);
    #3 rst = 1'b1;
    #1;
    check_eq("rw_rst_valid",   {63'd0, ws_valid}, 64'd0);
    check_eq("rw_rst_allowin", {63'd0, ws_allowin}, 64'd1);
    check_eq("rw_rst_pc",      ws_pc, 64'd0);
    check_eq("rw_rst_minstret", minstret, 64'd0);
    rst = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 64'h1234;
    tick();
    drive_idle();
    check_eq("late_valid",   {63'd0, ws_valid}, 64'd0);
    check_eq("late_allowin", {63'd0, ws_allowin}, 64'd1);
    check_eq("late_wdata",   gpr_wdata, 64'd0);
    tick();
    check_eq("late2_valid",    {63'd0, ws_valid}, 64'd0);
    check_eq("late2_minstret", minstret, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
